// File: rtl/frida_conv_seq_if.sv
// Result port of the FRIDA conversion sequencer: one raw bit word per ADC.
// The sequencer drives the master side; the consumer acknowledges with result_ready.
interface frida_conv_seq_if;
  logic [15:0] result;
  logic [3:0]  result_adc;
  logic        result_valid;
  logic        result_ready;

  modport master (output result, output result_adc, output result_valid, input result_ready);
  modport slave  (input result, input result_adc, input result_valid, output result_ready);
endinterface

// File: rtl/frida_conv_seq.sv
// FRIDA conversion sequencer: generates the INIT/SAMP/COMP/LOGIC phase strobes,
// scans the enabled ADCs round-robin and returns each captured bit word.
module frida_conv_seq (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic                    i_cont,
  input  logic [15:0]             i_adc_mask,
  input  logic [3:0]              i_t_init,
  input  logic [3:0]              i_t_samp,
  input  logic [3:0]              i_t_comp,
  input  logic [3:0]              i_t_logic,
  input  logic [3:0]              i_n_cyc,
  input  logic                    i_comp_out,
  output logic                    o_seq_init,
  output logic                    o_seq_samp,
  output logic                    o_seq_comp,
  output logic                    o_seq_logic,
  output logic [3:0]              o_mux_sel,
  output logic                    o_busy,
  frida_conv_seq_if.master        res_if
);

  localparam int NADC  = 16;
  localparam int NBMAX = 16;

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_SAMP, S_COMP, S_LOGIC, S_DONE} state_t;

  state_t             r_state, w_state_next;
  logic [3:0]         r_cnt, r_bit;
  logic [NBMAX-1:0]   r_sh, r_result;
  logic [3:0]         r_t_init, r_t_samp, r_t_comp, r_t_logic, r_n_cyc;
  logic [3:0]         r_mux_sel, r_last, r_result_adc;
  logic               r_valid, r_busy;
  logic               r_seq_init, r_seq_samp, r_seq_comp, r_seq_logic;

  logic [NADC-1:0]    w_rot;
  logic [3:0]         w_off, w_next_idx;
  logic               w_mask_any, w_load, w_shift, w_bit_inc;

  // Mask rotated so that bit 0 is the ADC right after the last converted one.
  generate
    for (genvar gi = 0; gi < NADC; gi++) begin : g_rot
      assign w_rot[gi] = i_adc_mask[r_last + 4'(gi + 1)];
    end
  endgenerate

  always_comb begin
    w_off = '0;
    for (int i = NADC - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = 4'(i);
    end
  end

  assign w_next_idx = r_last + 4'd1 + w_off;
  assign w_mask_any = |i_adc_mask;

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_bit_inc    = 1'b0;
    unique case (r_state)
      S_IDLE:  if (i_start && w_mask_any) begin
                 w_state_next = S_INIT;
                 w_load       = 1'b1;
               end
      S_INIT:  if (r_cnt == r_t_init) w_state_next = S_SAMP;
      S_SAMP:  if (r_cnt == r_t_samp) w_state_next = S_COMP;
      S_COMP:  if (r_cnt == r_t_comp) begin
                 w_state_next = S_LOGIC;
                 w_shift      = 1'b1;
               end
      S_LOGIC: if (r_cnt == r_t_logic) begin
                 if (r_bit == r_n_cyc) begin
                   w_state_next = S_DONE;
                 end else begin
                   w_state_next = S_COMP;
                   w_bit_inc    = 1'b1;
                 end
               end
      S_DONE:  if (res_if.result_ready) begin
                 if (i_cont && w_mask_any) begin
                   w_state_next = S_INIT;
                   w_load       = 1'b1;
                 end else begin
                   w_state_next = S_IDLE;
                 end
               end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_sh         <= '0;
      r_t_init     <= '0;
      r_t_samp     <= '0;
      r_t_comp     <= '0;
      r_t_logic    <= '0;
      r_n_cyc      <= '0;
      r_mux_sel    <= '0;
      r_last       <= 4'd15;
      r_result     <= '0;
      r_result_adc <= '0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_seq_init   <= 1'b0;
      r_seq_samp   <= 1'b0;
      r_seq_comp   <= 1'b0;
      r_seq_logic  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= (w_state_next != r_state) ? 4'd0 : r_cnt + 4'd1;
      if (w_load) begin
        r_t_init  <= i_t_init;
        r_t_samp  <= i_t_samp;
        r_t_comp  <= i_t_comp;
        r_t_logic <= i_t_logic;
        r_n_cyc   <= i_n_cyc;
        r_mux_sel <= w_next_idx;
        r_last    <= w_next_idx;
        r_bit     <= '0;
        r_sh      <= '0;
      end
      if (w_shift)   r_sh  <= {r_sh[NBMAX-2:0], i_comp_out};
      if (w_bit_inc) r_bit <= r_bit + 4'd1;
      // Result is latched once on DONE entry so it stays stable under backpressure.
      if (w_state_next == S_DONE && r_state != S_DONE) begin
        r_result     <= r_sh;
        r_result_adc <= r_mux_sel;
      end
      r_valid     <= (w_state_next == S_DONE);
      r_busy      <= (w_state_next != S_IDLE);
      r_seq_init  <= (w_state_next == S_INIT);
      r_seq_samp  <= (w_state_next == S_SAMP);
      r_seq_comp  <= (w_state_next == S_COMP);
      r_seq_logic <= (w_state_next == S_LOGIC);
    end
  end

  assign o_seq_init          = r_seq_init;
  assign o_seq_samp          = r_seq_samp;
  assign o_seq_comp          = r_seq_comp;
  assign o_seq_logic         = r_seq_logic;
  assign o_mux_sel           = r_mux_sel;
  assign o_busy              = r_busy;
  assign res_if.result       = r_result;
  assign res_if.result_adc   = r_result_adc;
  assign res_if.result_valid = r_valid;

endmodule

// File: tb/tb_frida_conv_seq.sv
// Self-checking bench for frida_conv_seq: directed vectors, corner sequences and
// randomized conversions checked cycle by cycle against a phase-schedule model.
module tb_frida_conv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start, i_cont, i_comp_out;
  logic [15:0] i_adc_mask;
  logic [3:0]  i_t_init, i_t_samp, i_t_comp, i_t_logic, i_n_cyc;
  logic        o_seq_init, o_seq_samp, o_seq_comp, o_seq_logic, o_busy;
  logic [3:0]  o_mux_sel;

  frida_conv_seq_if res_if();

  always #5 clk = ~clk;

  frida_conv_seq dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_cont      (i_cont),
    .i_adc_mask  (i_adc_mask),
    .i_t_init    (i_t_init),
    .i_t_samp    (i_t_samp),
    .i_t_comp    (i_t_comp),
    .i_t_logic   (i_t_logic),
    .i_n_cyc     (i_n_cyc),
    .i_comp_out  (i_comp_out),
    .o_seq_init  (o_seq_init),
    .o_seq_samp  (o_seq_samp),
    .o_seq_comp  (o_seq_comp),
    .o_seq_logic (o_seq_logic),
    .o_mux_sel   (o_mux_sel),
    .o_busy      (o_busy),
    .res_if      (res_if)
  );

  typedef struct {
    logic [3:0]  ti, ts, tc, tl, nc;
    logic [15:0] mask;
    logic [15:0] bits;
    int          delay;
    logic [15:0] exp_result;
    logic [3:0]  exp_adc;
  } vec_t;

  int         n_checks = 0;
  int         n_errors = 0;
  int         n_conv   = 0;
  logic [3:0] m_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // {init,samp,comp,logic, busy, valid, mux_sel}
  function automatic logic [9:0] obs();
    return {o_seq_init, o_seq_samp, o_seq_comp, o_seq_logic, o_busy,
            res_if.result_valid, o_mux_sel};
  endfunction

  // Next enabled ADC searching upward from last+1, wrapping at 16.
  function automatic logic [3:0] model_next(input logic [15:0] mask, input logic [3:0] last);
    logic [3:0] idx;
    model_next = last;
    for (int i = 16; i >= 1; i--) begin
      idx = 4'((int'(last) + i) % 16);
      if (mask[idx]) model_next = idx;
    end
  endfunction

  function automatic vec_t mk(input int ti, input int ts, input int tc, input int tl,
                              input int nc, input int mask, input int bits, input int delay,
                              input int exp_result, input int exp_adc);
    vec_t v;
    v.ti = 4'(ti); v.ts = 4'(ts); v.tc = 4'(tc); v.tl = 4'(tl); v.nc = 4'(nc);
    v.mask = 16'(mask); v.bits = 16'(bits); v.delay = delay;
    v.exp_result = 16'(exp_result); v.exp_adc = 4'(exp_adc);
    return v;
  endfunction

  // One conversion. Enters just after an edge; with do_start=0 the DUT must already be in INIT.
  task automatic run_conv(input vec_t v, input logic cont, input logic do_start, input logic scramble);
    int         sched[$];
    int         bitn;
    int         code;
    logic [3:0] exp_strobe;
    sched.delete();
    for (int i = 0; i <= int'(v.ti); i++) sched.push_back(0);
    for (int i = 0; i <= int'(v.ts); i++) sched.push_back(1);
    for (int b = 0; b <= int'(v.nc); b++) begin
      for (int c = 0; c <= int'(v.tc); c++) sched.push_back((c == int'(v.tc)) ? 4 : 2);
      for (int c = 0; c <= int'(v.tl); c++) sched.push_back(3);
    end
    i_t_init = v.ti; i_t_samp = v.ts; i_t_comp = v.tc; i_t_logic = v.tl; i_n_cyc = v.nc;
    i_adc_mask = v.mask;
    i_cont = cont;
    res_if.result_ready = (v.delay == 0);
    if (do_start) begin
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
    end
    if (scramble) begin
      i_t_init = 4'($urandom); i_t_samp = 4'($urandom);
      i_t_comp = 4'($urandom); i_t_logic = 4'($urandom); i_n_cyc = 4'($urandom);
    end
    m_last = v.exp_adc;
    bitn = 0;
    for (int k = 0; k < sched.size(); k++) begin
      code = sched[k];
      exp_strobe = (code == 0) ? 4'b1000 : (code == 1) ? 4'b0100 :
                   (code == 3) ? 4'b0001 : 4'b0010;
      chk("cycle", 32'(obs()), 32'({exp_strobe, 1'b1, 1'b0, v.exp_adc}));
      if (code == 4) begin
        i_comp_out = v.bits[int'(v.nc) - bitn];
        bitn++;
      end else if (code == 2) begin
        i_comp_out = ~v.bits[int'(v.nc) - bitn];
      end else begin
        i_comp_out = 1'($urandom);
      end
      @(posedge clk); #1;
    end
    for (int h = 0; h <= v.delay; h++) begin
      chk("done", 32'(obs()), 32'({4'b0000, 1'b1, 1'b1, v.exp_adc}));
      chk("result", 32'(res_if.result), 32'(v.exp_result));
      chk("result_adc", 32'(res_if.result_adc), 32'(v.exp_adc));
      if (h == v.delay) res_if.result_ready = 1'b1;
      @(posedge clk); #1;
    end
    res_if.result_ready = 1'b0;
    $display("conv %0d: adc=%0d result=%h len=%0d hold=%0d cont=%0b", n_conv,
             res_if.result_adc, res_if.result, sched.size(), v.delay + 1, cont);
    n_conv++;
    if (!cont) chk("idle_after", 32'(obs()), 32'({4'b0000, 1'b0, 1'b0, v.exp_adc}));
  endtask

  vec_t       vt[4];
  vec_t       v;
  int         exp_scan[5];
  int         seen;
  logic [31:0] wm;

  initial begin
    rst = 1'b1; i_start = 1'b0; i_cont = 1'b0; i_comp_out = 1'b0; i_adc_mask = '0;
    i_t_init = '0; i_t_samp = '0; i_t_comp = '0; i_t_logic = '0; i_n_cyc = '0;
    res_if.result_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 32'(obs()), 32'h0);
    chk("reset_result", 32'(res_if.result), 32'h0);
    chk("reset_result_adc", 32'(res_if.result_adc), 32'h0);
    rst = 1'b0;
    m_last = 4'd15;
    @(posedge clk); #1;

    vt[0] = mk(0, 0, 0, 0, 3,  16'h0001, 16'h000B, 0, 16'h000B, 0);
    vt[1] = mk(2, 5, 1, 0, 0,  16'h0001, 16'h0001, 0, 16'h0001, 0);
    vt[2] = mk(1, 0, 0, 1, 4,  16'h0010, 16'h0015, 7, 16'h0015, 4);
    vt[3] = mk(0, 0, 1, 0, 15, 16'h0010, 16'hAAAA, 0, 16'hAAAA, 4);
    for (int i = 0; i < 4; i++) run_conv(vt[i], 1'b0, 1'b1, (i == 3));

    // Reset on the third COMP cycle of a long conversion.
    i_t_init = 0; i_t_samp = 0; i_t_comp = 0; i_t_logic = 0; i_n_cyc = 4'd15;
    i_adc_mask = 16'h0008; i_cont = 1'b0; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (6) begin
      i_comp_out = 1'($urandom);
      @(posedge clk); #1;
    end
    chk("rst_third_comp", 32'(obs()), 32'({4'b0010, 1'b1, 1'b0, 4'd3}));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_outs", 32'(obs()), 32'h0);
    chk("rst_mid_result", 32'({res_if.result, res_if.result_adc}), 32'h0);
    rst = 1'b0;
    m_last = 4'd15;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (res_if.result_valid || o_busy) seen++;
    end
    chk("rst_no_result", 32'(seen), 32'h0);
    run_conv(mk(0, 1, 0, 0, 2, 16'h0002, 16'h0005, 1, 16'h0005, 1), 1'b0, 1'b1, 1'b0);

    // Round-robin continuous scan from a fresh reset.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_last = 4'd15;
    exp_scan = '{0, 5, 10, 15, 0};
    for (int j = 0; j < 5; j++) begin
      v = mk(1, 0, 0, 1, 1, 16'h8421, int'($urandom_range(0, 3)), 0, 0, exp_scan[j]);
      v.exp_result = {14'd0, v.bits[1:0]};
      run_conv(v, (j < 4), (j == 0), 1'b0);
    end

    // Empty mask: start must be ignored.
    i_adc_mask = 16'h0000;
    i_start = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      chk("zero_mask_busy", 32'({o_busy, o_seq_init}), 32'h0);
    end
    i_start = 1'b0;

    // Randomized conversions against the model.
    for (int r = 0; r < 25; r++) begin
      v.ti = 4'($urandom); v.ts = 4'($urandom); v.tc = 4'($urandom % 4);
      v.tl = 4'($urandom % 4); v.nc = 4'($urandom);
      v.mask = 16'($urandom);
      if (v.mask == 16'h0) v.mask = 16'h0100;
      v.bits = 16'($urandom);
      v.delay = int'($urandom_range(0, 3));
      wm = (32'h1 << (int'(v.nc) + 1)) - 32'h1;
      v.exp_result = v.bits & wm[15:0];
      v.exp_adc = model_next(v.mask, m_last);
      run_conv(v, 1'b0, 1'b1, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
